// File: rtl/eth_tx_framer_pkg.sv
// Shared definitions for the Ethernet transmit framer and the receive-side FCS
// checker: line constants, the framer state type and a byte-wise CRC-32 step.
package eth_tx_framer_pkg;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } eth_tx_state_t;

    // One byte of the reflected CRC-32, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  dataByte);
        logic [31:0] c;
        c = crc ^ {24'h000000, dataByte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Registered byte-wise CRC-32 accumulator.
// Ports:
//   clkIn    clock
//   rstNIn   asynchronous active-low reset (CRC returns to the initial value)
//   clearIn  reload the initial value (takes priority over enIn)
//   enIn     fold dataIn into the CRC this cycle
//   dataIn   byte to fold in
//   crcOut   current CRC register (not inverted)
module eth_crc32 (
    input  logic        clkIn,
    input  logic        rstNIn,
    input  logic        clearIn,
    input  logic        enIn,
    input  logic [7:0]  dataIn,
    output logic [31:0] crcOut
);
    import eth_tx_framer_pkg::*;

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            crcOut <= CRC32_INIT;
        end else if (clearIn) begin
            crcOut <= CRC32_INIT;
        end else if (enIn) begin
            crcOut <= crc32_byte(crcOut, dataIn);
        end
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: turns a valid/ready/last payload stream into a
// GMII byte stream (preamble, SFD, payload, zero pad, FCS, inter-frame gap).
// Ports:
//   clkIn        125MHz transmit clock
//   rstNIn       asynchronous active-low reset
//   txDataIn     payload byte
//   txValidIn    payload byte valid
//   txLastIn     final payload byte, qualified by txValidIn
//   txReadyOut   byte on txDataIn is taken this cycle (DATA state only)
//   phyDataOut   registered byte to PHY
//   phyEnOut     registered transmit enable
//   phyErOut     registered transmit error
//   underrunOut  one-cycle pulse, stream starved mid-frame
//   oversizeOut  one-cycle pulse, frame longer than MAX_PAYLOAD
//
// state    | meaning
// IDLE     | waiting for txValidIn; CRC held at its initial value
// PREAMBLE | launching preamble bytes 2..7
// SFD      | launching the SFD byte
// DATA     | accepting payload; txReadyOut high
// PAD      | launching zero pad bytes up to MIN_PAYLOAD
// FCS      | launching the four inverted CRC bytes, LSB first
// IFG      | forced idle for IFG_BYTES cycles (IFG_BYTES must be >= 1)
module eth_tx_framer #(
    parameter int MIN_PAYLOAD = 60,
    parameter int MAX_PAYLOAD = 1514,
    parameter int IFG_BYTES   = 12
) (
    input  logic       clkIn,
    input  logic       rstNIn,
    input  logic [7:0] txDataIn,
    input  logic       txValidIn,
    input  logic       txLastIn,
    output logic       txReadyOut,
    output logic [7:0] phyDataOut,
    output logic       phyEnOut,
    output logic       phyErOut,
    output logic       underrunOut,
    output logic       oversizeOut
);
    import eth_tx_framer_pkg::*;

    localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] SAT_CNT  = 11'(MAX_PAYLOAD + 1);
    localparam logic [10:0] IFG_LOAD = 11'(IFG_BYTES - 1);
    // Preamble byte 1 is launched from IDLE and byte 7 from PREAMBLE's last
    // cycle, so PREAMBLE itself lasts six cycles.
    localparam logic [10:0] PRE_LOAD = 11'd5;
    localparam logic [10:0] FCS_LOAD = 11'd3;

    eth_tx_state_t state;
    logic [10:0]   tmrCnt;
    logic [10:0]   payCnt;
    logic [10:0]   payCntNext;
    logic          overFlag;
    logic          hitMax;
    logic          crcClear;
    logic          crcEn;
    logic [7:0]    crcData;
    logic [31:0]   crcVal;
    logic [7:0]    fcsByte;

    assign txReadyOut = (state == DATA);
    assign payCntNext = (payCnt == SAT_CNT) ? payCnt : payCnt + 11'd1;
    assign hitMax     = (payCnt == MAX_CNT);

    assign crcClear = (state == IDLE);
    assign crcEn    = ((state == DATA) && txValidIn) || (state == PAD);
    assign crcData  = (state == PAD) ? 8'h00 : txDataIn;

    eth_crc32 crcInst (
        .clkIn   (clkIn),
        .rstNIn  (rstNIn),
        .clearIn (crcClear),
        .enIn    (crcEn),
        .dataIn  (crcData),
        .crcOut  (crcVal)
    );

    // tmrCnt counts 3..0 in FCS, so 3 selects the least significant byte.
    always_comb begin
        fcsByte = 8'h00;
        case (tmrCnt[1:0])
            2'd3:    fcsByte = ~crcVal[7:0];
            2'd2:    fcsByte = ~crcVal[15:8];
            2'd1:    fcsByte = ~crcVal[23:16];
            default: fcsByte = ~crcVal[31:24];
        endcase
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            state       <= IDLE;
            tmrCnt      <= '0;
            payCnt      <= '0;
            overFlag    <= 1'b0;
            phyDataOut  <= 8'h00;
            phyEnOut    <= 1'b0;
            phyErOut    <= 1'b0;
            underrunOut <= 1'b0;
            oversizeOut <= 1'b0;
        end else begin
            underrunOut <= 1'b0;
            oversizeOut <= 1'b0;
            case (state)
                IDLE: begin
                    phyDataOut <= 8'h00;
                    phyEnOut   <= 1'b0;
                    phyErOut   <= 1'b0;
                    payCnt     <= '0;
                    overFlag   <= 1'b0;
                    if (txValidIn) begin
                        state      <= PREAMBLE;
                        tmrCnt     <= PRE_LOAD;
                        phyDataOut <= ETH_PREAMBLE;
                        phyEnOut   <= 1'b1;
                    end
                end
                PREAMBLE: begin
                    phyDataOut <= ETH_PREAMBLE;
                    phyEnOut   <= 1'b1;
                    if (tmrCnt == '0) begin
                        state <= SFD;
                    end else begin
                        tmrCnt <= tmrCnt - 11'd1;
                    end
                end
                SFD: begin
                    phyDataOut <= ETH_SFD;
                    phyEnOut   <= 1'b1;
                    state      <= DATA;
                end
                DATA: begin
                    phyEnOut <= 1'b1;
                    if (txValidIn) begin
                        phyDataOut <= txDataIn;
                        phyErOut   <= overFlag || hitMax;
                        payCnt     <= payCntNext;
                        if (hitMax) begin
                            overFlag    <= 1'b1;
                            oversizeOut <= 1'b1;
                        end
                        if (txLastIn) begin
                            if (overFlag || hitMax) begin
                                state  <= IFG;
                                tmrCnt <= IFG_LOAD;
                            end else if (payCntNext < MIN_CNT) begin
                                state <= PAD;
                            end else begin
                                state  <= FCS;
                                tmrCnt <= FCS_LOAD;
                            end
                        end
                    end else begin
                        // Starved mid-frame: poison the frame and abandon it.
                        phyDataOut  <= 8'h00;
                        phyErOut    <= 1'b1;
                        underrunOut <= 1'b1;
                        state       <= IFG;
                        tmrCnt      <= IFG_LOAD;
                    end
                end
                PAD: begin
                    phyDataOut <= 8'h00;
                    phyEnOut   <= 1'b1;
                    phyErOut   <= 1'b0;
                    payCnt     <= payCntNext;
                    if (payCntNext >= MIN_CNT) begin
                        state  <= FCS;
                        tmrCnt <= FCS_LOAD;
                    end
                end
                FCS: begin
                    phyDataOut <= fcsByte;
                    phyEnOut   <= 1'b1;
                    phyErOut   <= 1'b0;
                    if (tmrCnt == '0) begin
                        state  <= IFG;
                        tmrCnt <= IFG_LOAD;
                    end else begin
                        tmrCnt <= tmrCnt - 11'd1;
                    end
                end
                IFG: begin
                    phyDataOut <= 8'h00;
                    phyEnOut   <= 1'b0;
                    phyErOut   <= 1'b0;
                    if (tmrCnt == '0) begin
                        state <= IDLE;
                    end else begin
                        tmrCnt <= tmrCnt - 11'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer. dutA runs MIN_PAYLOAD=0/MAX_PAYLOAD=100, dutB the
// defaults. Expected PHY bytes are queued per DUT when a frame is scheduled and
// popped by a monitor on every enabled cycle.
module tb_eth_tx_framer;

    typedef struct packed {
        logic [7:0] data;
        logic       er;
        logic       ovr;
        logic       und;
    } expByte_t;

    logic       clk = 1'b0;
    logic       rstN     [2];
    logic [7:0] txData   [2];
    logic       txValid  [2];
    logic       txLast   [2];
    logic       txReady  [2];
    logic [7:0] phyData  [2];
    logic       phyEn    [2];
    logic       phyEr    [2];
    logic       underrun [2];
    logic       oversize [2];

    always #4 clk = ~clk;

    eth_tx_framer #(.MIN_PAYLOAD(0), .MAX_PAYLOAD(100), .IFG_BYTES(12)) dutA (
        .clkIn(clk), .rstNIn(rstN[0]), .txDataIn(txData[0]), .txValidIn(txValid[0]),
        .txLastIn(txLast[0]), .txReadyOut(txReady[0]), .phyDataOut(phyData[0]),
        .phyEnOut(phyEn[0]), .phyErOut(phyEr[0]), .underrunOut(underrun[0]),
        .oversizeOut(oversize[0])
    );

    eth_tx_framer #(.MIN_PAYLOAD(60), .MAX_PAYLOAD(1514), .IFG_BYTES(12)) dutB (
        .clkIn(clk), .rstNIn(rstN[1]), .txDataIn(txData[1]), .txValidIn(txValid[1]),
        .txLastIn(txLast[1]), .txReadyOut(txReady[1]), .phyDataOut(phyData[1]),
        .phyEnOut(phyEn[1]), .phyErOut(phyEr[1]), .underrunOut(underrun[1]),
        .oversizeOut(oversize[1])
    );

    int checks = 0;
    int errors = 0;

    expByte_t   expQ   [2][$];
    int         hiRuns [2][$];
    int         loRuns [2][$];
    int         hiLen  [2];
    int         loLen  [2];
    bit         seen   [2];
    logic [7:0] curPay [$];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic expByte_t mk(input logic [7:0] dt, input logic e, input logic o, input logic u);
        expByte_t r;
        r = {dt, e, o, u};
        return r;
    endfunction

    // Bit-serial reflected CRC-32 reference.
    function automatic logic [31:0] modelCrc(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ b[k];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstN[d]) begin
                hiLen[d] = 0;
                loLen[d] = 0;
                seen[d]  = 1'b0;
            end else if (phyEn[d]) begin
                if (seen[d] && loLen[d] > 0) loRuns[d].push_back(loLen[d]);
                loLen[d] = 0;
                hiLen[d]++;
                checkVal($sformatf("dut%0d byte expected", d), 32'(expQ[d].size() != 0), 32'd1);
                if (expQ[d].size() != 0) begin
                    expByte_t e;
                    e = expQ[d].pop_front();
                    checkVal($sformatf("dut%0d tx byte %0d {data,er,ovr,und}", d, hiLen[d]),
                             32'({phyData[d], phyEr[d], oversize[d], underrun[d]}), 32'(e));
                end
            end else begin
                if (hiLen[d] > 0) begin
                    hiRuns[d].push_back(hiLen[d]);
                    hiLen[d] = 0;
                    seen[d]  = 1'b1;
                end
                if (seen[d]) loLen[d]++;
                checkVal($sformatf("dut%0d idle outputs", d),
                         32'({phyData[d], phyEr[d], oversize[d], underrun[d]}), 32'd0);
            end
        end
    end

    task automatic pushHeader(input int d);
        for (int i = 0; i < 7; i++) expQ[d].push_back(mk(8'h55, 1'b0, 1'b0, 1'b0));
        expQ[d].push_back(mk(8'hD5, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic pushFrame(input int d, input int minP, input int maxP, input int stopAt);
        logic [31:0] c;
        int          cnt;
        c = 32'hFFFFFFFF;
        pushHeader(d);
        if (stopAt > 0) begin
            for (int i = 0; i < stopAt; i++) expQ[d].push_back(mk(curPay[i], 1'b0, 1'b0, 1'b0));
            expQ[d].push_back(mk(8'h00, 1'b1, 1'b0, 1'b1));
            return;
        end
        for (int i = 0; i < curPay.size(); i++) begin
            expQ[d].push_back(mk(curPay[i], i >= maxP, i == maxP, 1'b0));
            c = modelCrc(c, curPay[i]);
        end
        if (curPay.size() > maxP) return;
        cnt = curPay.size();
        while (cnt < minP) begin
            expQ[d].push_back(mk(8'h00, 1'b0, 1'b0, 1'b0));
            c = modelCrc(c, 8'h00);
            cnt++;
        end
        c = ~c;
        for (int k = 0; k < 4; k++) expQ[d].push_back(mk(c[8*k +: 8], 1'b0, 1'b0, 1'b0));
    endtask

    task automatic randPay(input int n);
        curPay.delete();
        for (int i = 0; i < n; i++) curPay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic driveFrame(input int d, input int stopAt, input int rstAt);
        int   i;
        int   guard;
        logic rdy;
        i     = 0;
        guard = 0;
        while (i < curPay.size()) begin
            if (stopAt > 0 && i == stopAt) begin
                txValid[d] = 1'b0;
                txLast[d]  = 1'b0;
                @(posedge clk); #1;
                break;
            end
            txValid[d] = 1'b1;
            txData[d]  = curPay[i];
            txLast[d]  = (i == curPay.size() - 1);
            @(negedge clk);
            rdy = txReady[d];
            @(posedge clk); #1;
            if (rdy) i++;
            if (rdy && rstAt > 0 && i == rstAt) begin
                #1 rstN[d] = 1'b0;
                #1;
                checkVal("reset mid-frame phyEn", 32'(phyEn[d]), 32'd0);
                checkVal("reset mid-frame txReady", 32'(txReady[d]), 32'd0);
                expQ[d].delete();
                txValid[d] = 1'b0;
                txLast[d]  = 1'b0;
                @(negedge clk); @(negedge clk); #1;
                rstN[d] = 1'b1;
                @(posedge clk); #1;
                break;
            end
            guard++;
            if (guard > 4000) begin
                checkVal("driver stalled, bytes accepted", 32'(i), 32'(curPay.size()));
                break;
            end
        end
        txValid[d] = 1'b0;
        txLast[d]  = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while ((expQ[d].size() != 0 || phyEn[d]) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (20) @(posedge clk);
        #1;
        checkVal($sformatf("dut%0d expected bytes left", d), 32'(expQ[d].size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fcs1 [4];
        int hb;
        int lb;
        fcs1 = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        for (int d = 0; d < 2; d++) begin
            rstN[d]    = 1'b0;
            txData[d]  = 8'h00;
            txValid[d] = 1'b0;
            txLast[d]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkVal($sformatf("dut%0d reset txReady", d), 32'(txReady[d]), 32'd0);
            checkVal($sformatf("dut%0d reset phyEn", d), 32'(phyEn[d]), 32'd0);
            checkVal($sformatf("dut%0d reset phyEr", d), 32'(phyEr[d]), 32'd0);
            checkVal($sformatf("dut%0d reset phyData", d), 32'(phyData[d]), 32'd0);
            checkVal($sformatf("dut%0d reset underrun", d), 32'(underrun[d]), 32'd0);
            checkVal($sformatf("dut%0d reset oversize", d), 32'(oversize[d]), 32'd0);
            rstN[d] = 1'b1;
        end
        @(posedge clk); #1;

        // 1: check-value frame on dutA (no pad), then a back-to-back frame
        hb = hiRuns[0].size();
        lb = loRuns[0].size() + (seen[0] ? 1 : 0);
        curPay.delete();
        for (int i = 0; i < 9; i++) curPay.push_back(8'h31 + 8'(i));
        pushHeader(0);
        for (int i = 0; i < 9; i++) expQ[0].push_back(mk(curPay[i], 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 4; k++) expQ[0].push_back(mk(fcs1[k], 1'b0, 1'b0, 1'b0));
        driveFrame(0, 0, 0);
        randPay(5);
        pushFrame(0, 0, 100, 0);
        driveFrame(0, 0, 0);
        drain(0);
        checkVal("t1 phyEn high cycles", 32'(hiRuns[0][hb]), 32'd21);
        checkVal("t1 idle gap", 32'(loRuns[0][lb]), 32'd12);
        checkVal("t1 second frame high cycles", 32'(hiRuns[0][hb+1]), 32'd17);

        // 2: 14-byte frame padded to 60
        hb = hiRuns[1].size();
        randPay(14);
        pushFrame(1, 60, 1514, 0);
        driveFrame(1, 0, 0);
        drain(1);
        checkVal("t2 phyEn high cycles", 32'(hiRuns[1][hb]), 32'd72);

        // 3: 60, 59 and 61 byte frames back to back
        hb = hiRuns[1].size();
        lb = loRuns[1].size() + (seen[1] ? 1 : 0);
        randPay(60); pushFrame(1, 60, 1514, 0); driveFrame(1, 0, 0);
        randPay(59); pushFrame(1, 60, 1514, 0); driveFrame(1, 0, 0);
        randPay(61); pushFrame(1, 60, 1514, 0); driveFrame(1, 0, 0);
        drain(1);
        checkVal("t3 60-byte high cycles", 32'(hiRuns[1][hb]), 32'd72);
        checkVal("t3 59-byte high cycles", 32'(hiRuns[1][hb+1]), 32'd72);
        checkVal("t3 61-byte high cycles", 32'(hiRuns[1][hb+2]), 32'd73);
        checkVal("t3 gap 1", 32'(loRuns[1][lb]), 32'd12);
        checkVal("t3 gap 2", 32'(loRuns[1][lb+1]), 32'd12);

        // 4: underrun after byte 20 of a 64-byte frame, then a normal frame
        hb = hiRuns[1].size();
        lb = loRuns[1].size() + (seen[1] ? 1 : 0);
        randPay(64); pushFrame(1, 60, 1514, 20); driveFrame(1, 20, 0);
        randPay(61); pushFrame(1, 60, 1514, 0); driveFrame(1, 0, 0);
        drain(1);
        checkVal("t4 underrun frame high cycles", 32'(hiRuns[1][hb]), 32'd29);
        checkVal("t4 gap after underrun", 32'(loRuns[1][lb]), 32'd12);
        checkVal("t4 next frame high cycles", 32'(hiRuns[1][hb+1]), 32'd73);

        // 5: 120-byte oversize frame on dutA, then exactly MAX_PAYLOAD bytes
        hb = hiRuns[0].size();
        lb = loRuns[0].size() + (seen[0] ? 1 : 0);
        randPay(120); pushFrame(0, 0, 100, 0); driveFrame(0, 0, 0);
        randPay(100); pushFrame(0, 0, 100, 0); driveFrame(0, 0, 0);
        drain(0);
        checkVal("t5 oversize high cycles", 32'(hiRuns[0][hb]), 32'd128);
        checkVal("t5 gap after oversize", 32'(loRuns[0][lb]), 32'd12);
        checkVal("t5 max-size high cycles", 32'(hiRuns[0][hb+1]), 32'd112);

        // 6: reset at byte 10, then a fresh 30-byte frame
        hb = hiRuns[1].size();
        randPay(64); pushFrame(1, 60, 1514, 0); driveFrame(1, 0, 10);
        randPay(30); pushFrame(1, 60, 1514, 0); driveFrame(1, 0, 0);
        drain(1);
        checkVal("t6 frame after reset high cycles", 32'(hiRuns[1][hb]), 32'd72);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
